// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control, muldiv op encodings and sequencer state
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_REM  = 2'b11;

  localparam int MD_LATENCY = 35;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - shift-add multiply / restoring divide borrowing the shared ALU
// Signed operation is built only with MULDIV_SIGNED_EN defined; latency is 35 cycles either way.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [1:0]        op_q, op_d;

  logic [XLEN-1:0]   mag_a, mag_b, s, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic              carry, borrow, msb;

`ifdef MULDIV_SIGNED_EN
  logic sgn_q, sgn_d, neg_res_q, neg_res_d, neg_a_q, neg_a_d;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      op_q      <= MD_MUL;
`ifdef MULDIV_SIGNED_EN
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      op_q      <= op_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    op_d     = op_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    mag_a    = opa_q;
    mag_b    = opb_q;
    s        = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    msb      = hi_q[XLEN-1];
    carry    = 1'b0;
    borrow   = 1'b0;
    prod     = {hi_q, lo_q};
    quo      = lo_q;
    rem      = hi_q;
`ifdef MULDIV_SIGNED_EN
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    if (sgn_q && opa_q[XLEN-1]) mag_a = -opa_q;
    if (sgn_q && opb_q[XLEN-1]) mag_b = -opb_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PREP;
          opa_d   = a;
          opb_d   = b;
          op_d    = op;
`ifdef MULDIV_SIGNED_EN
          sgn_d   = sgn;
`endif
        end
      end

      ST_PREP: begin
        state_d = ST_ITER;
        cnt_d   = '0;
        hi_d    = '0;
        // divide shifts the dividend out of lo; multiply shifts the multiplier out of lo
        lo_d    = op_q[1] ? mag_a : mag_b;
        opd_d   = op_q[1] ? mag_b : mag_a;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = sgn_q & (opa_q[XLEN-1] ^ opb_q[XLEN-1]);
        neg_a_d   = sgn_q & opa_q[XLEN-1];
`endif
      end

      ST_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
        if (!op_q[1]) begin
          alu_a = hi_q;
          if (lo_q[0]) begin
            alu_b = opd_q;
            carry = (hi_q[XLEN-1] & opd_q[XLEN-1]) |
                    ((hi_q[XLEN-1] | opd_q[XLEN-1]) & ~alu_result[XLEN-1]);
            hi_d  = {carry, alu_result[XLEN-1:1]};
            lo_d  = {alu_result[0], lo_q[XLEN-1:1]};
          end else begin
            hi_d  = {1'b0, hi_q[XLEN-1:1]};
            lo_d  = {hi_q[0], lo_q[XLEN-1:1]};
          end
        end else begin
          alu_a    = s;
          alu_b    = opd_q;
          alu_ctrl = ALU_SUB;
          borrow   = (~s[XLEN-1] & opd_q[XLEN-1]) |
                     ((~s[XLEN-1] | opd_q[XLEN-1]) & alu_result[XLEN-1]);
          // msb is the 33rd remainder bit: when set the subtraction always fits
          if (msb | ~borrow) begin
            hi_d = alu_result;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = s;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
      end

      ST_FIX: begin
        state_d = ST_DONE;
`ifdef MULDIV_SIGNED_EN
        if (neg_res_q) begin
          prod = -prod;
          quo  = -quo;
        end
        if (neg_a_q) rem = -rem;
`endif
        if (opb_q == '0) quo = '1;
`ifdef MULDIV_SIGNED_EN
        if (sgn_q && opa_q == {1'b1, {(XLEN-1){1'b0}}} && opb_q == '1) begin
          quo = {1'b1, {(XLEN-1){1'b0}}};
          rem = '0;
        end
`endif
        case (op_q)
          MD_MUL:  res_d = prod[XLEN-1:0];
          MD_MULH: res_d = prod[2*XLEN-1:XLEN];
          MD_DIV:  res_d = quo;
          default: res_d = rem;
        endcase
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign alu_own = (state_q == ST_ITER);
  assign result  = res_q;

endmodule
